// File: rtl/hexd_scan_ctrl.sv
// hexd_scan_ctrl
//   Drives a 4-digit multiplexed 7-segment display from the 16-bit
//   hex-display register written over MMIO.
//
//   The 16-bit value is captured from the crossbar write port. Its four
//   nibbles are shown one at a time on shared segment lines. Each digit
//   owns a slot of SCAN_DIV clocks. The first DEAD_CYC clocks of every
//   slot keep all anodes off, so the previous digit's pattern cannot
//   ghost onto the next digit. Leading zero digits can optionally be
//   blanked.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_hexd_data  value to display; digit k = bits [4k+3:4k]
//   i_hexd_wren  write strobe; i_hexd_data is captured on a clock edge while high
//   o_seg        segments, bit0=a .. bit6=g (registered, pin polarity)
//   o_dp         decimal point, held inactive (registered, pin polarity)
//   o_an         digit enables, o_an[0] = rightmost digit (registered, pin polarity)

module hexd_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_hexd_data,
  input  logic        i_hexd_wren,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [3:0]  o_an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  // Active-high hex decode, bit6..bit0 = g..a.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] select_nibble(input logic [15:0] v,
                                               input logic [1:0]  i);
    logic [3:0] n;
    case (i)
      2'd0: n = v[3:0];
      2'd1: n = v[7:4];
      2'd2: n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

  // Digit k>0 is blanked when it and every digit to its left are zero.
  // Digit 0 is always shown so a zero value still displays "0".
  function automatic logic [3:0] leading_blank(input logic [15:0] v);
    logic [3:0] m;
    m = 4'h0;
    if (BLANK_LEADING != 0) begin
      m[1] = (v[15:4]  == 12'h000);
      m[2] = (v[15:8]  == 8'h00);
      m[3] = (v[15:12] == 4'h0);
    end
    return m;
  endfunction

  function automatic logic [6:0] seg_pins(input logic [6:0] s);
    return SEG_INV ? ~s : s;
  endfunction

  function automatic logic [3:0] an_pins(input logic [3:0] a);
    return AN_INV ? ~a : a;
  endfunction

  logic [15:0]      value_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       idx_p0;

  logic [6:0] seg_p1;
  logic       dp_p1;
  logic [3:0] an_p1;

  logic [3:0] blank_mask;
  logic [3:0] nib_sel;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  // ---- stage p0: captured value and scan position ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_p0 <= 16'h0000;
      cnt_p0   <= '0;
      idx_p0   <= 2'd0;
    end else begin
      if (i_hexd_wren) begin
        value_p0 <= i_hexd_data;
      end
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 2'd1;
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Outputs are derived from the pre-edge scan position and value, so the
  // anode and its segment pattern always switch on the same edge.
  always_comb begin
    blank_mask = leading_blank(value_p0);
    nib_sel    = select_nibble(value_p0, idx_p0);
    seg_next   = blank_mask[idx_p0] ? 7'h00 : hex_decode(nib_sel);
    an_next    = (cnt_p0 < DEAD_LIM) ? 4'h0 : (4'b0001 << idx_p0);
  end

  // ---- stage p1: pin registers ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_p1 <= seg_pins(7'h00);
      dp_p1  <= SEG_INV;
      an_p1  <= an_pins(4'h0);
    end else begin
      seg_p1 <= seg_pins(seg_next);
      dp_p1  <= SEG_INV;
      an_p1  <= an_pins(an_next);
    end
  end

  assign o_seg = seg_p1;
  assign o_dp  = dp_p1;
  assign o_an  = an_p1;

endmodule
